cmd_queue_controller: RTL and testbench

- Buffers 32-bit command words from the SPI receive path and issues them one at a time to the system controller's cmd_data/latch_data inputs.
- Generates a latch strobe with guaranteed setup, hold and gap timing, so the system controller's 3-sample latch synchronizer always sees a clean pulse.
- Optionally defers issue until the backend cycle controller reports an update cycle boundary.
- Sits between spi_controller and system_controller inside controller_unit.

---
 rtl/cmd_queue_controller_if.sv | 26 ++
 rtl/cmd_queue_controller.sv | 92 +++++++++
 tb/tb_cmd_queue_controller.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_queue_controller_if.sv
// cmd_queue_controller_if: command bus between the SPI receive path and the system controller.
interface cmd_queue_controller_if #(parameter int ADDR_WIDTH = 3) ();
    logic [31:0]         cmd_in;
    logic                cmd_in_valid;
    logic                sync_to_cycle;
    logic                update_cycle_complete;
    logic                hold;
    logic                clear_overflow;
    logic [31:0]         cmd_data;
    logic                latch_data;
    logic                busy;
    logic                fifo_empty;
    logic                fifo_full;
    logic [ADDR_WIDTH:0] fifo_level;
    logic                overflow;

    modport master (
        output cmd_in, cmd_in_valid, sync_to_cycle, update_cycle_complete, hold, clear_overflow,
        input  cmd_data, latch_data, busy, fifo_empty, fifo_full, fifo_level, overflow
    );

    modport slave (
        input  cmd_in, cmd_in_valid, sync_to_cycle, update_cycle_complete, hold, clear_overflow,
        output cmd_data, latch_data, busy, fifo_empty, fifo_full, fifo_level, overflow
    );
endinterface

// File: rtl/cmd_queue_controller.sv
// cmd_queue_controller: FIFO of command words issued one at a time with a timed latch strobe.
module cmd_queue_controller #(
    parameter int DEPTH        = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int SETUP_CYCLES = 2,
    parameter int HOLD_CYCLES  = 4,
    parameter int GAP_CYCLES   = 4
) (
    input logic                   clock,
    input logic                   reset_n,
    cmd_queue_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state, state_next;
    logic [7:0]            count, count_next;
    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   level;
    logic [31:0]           cmd_data;
    logic                  latch_data, overflow;
    logic                  empty, full, pop, push, drop;

    assign empty = level == '0;
    assign full  = level == FULL_LEVEL;
    assign pop   = state == IDLE && !empty && !bus.hold && (!bus.sync_to_cycle || bus.update_cycle_complete);
    assign push  = bus.cmd_in_valid && (!full || pop);
    assign drop  = bus.cmd_in_valid && !push;

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: if (pop) begin
                state_next = SETUP;
                count_next = 8'(SETUP_CYCLES - 1);
            end
            SETUP: if (count == '0) begin
                state_next = STROBE;
                count_next = 8'(HOLD_CYCLES - 1);
            end else count_next = count - 8'd1;
            STROBE: if (count == '0) begin
                state_next = GAP;
                count_next = 8'(GAP_CYCLES - 1);
            end else count_next = count - 8'd1;
            GAP: if (count == '0) state_next = IDLE;
                 else count_next = count - 8'd1;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            cmd_data   <= '0;
            latch_data <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            // Strobe is registered from the next state so it tracks STROBE exactly.
            latch_data <= state_next == STROBE;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                cmd_data <= mem[rd_ptr];
            end
            if (push && !pop) level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
            overflow <= drop || (overflow && !bus.clear_overflow);
        end
    end

    // Storage needs no reset; pointers and level define validity.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.cmd_in;
    end

    assign bus.cmd_data   = cmd_data;
    assign bus.latch_data = latch_data;
    assign bus.busy       = state != IDLE;
    assign bus.fifo_empty = empty;
    assign bus.fifo_full  = full;
    assign bus.fifo_level = level;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_cmd_queue_controller.sv
// tb_cmd_queue_controller: directed and random stimulus checked against a queue-based reference model.
module tb_cmd_queue_controller;
    localparam int DEPTH = 8;
    localparam int S     = 2;
    localparam int H     = 4;
    localparam int G     = 4;
    localparam int TOTAL = S + H + G;

    logic clock = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    cmd_queue_controller_if #(.ADDR_WIDTH(3)) bus ();

    cmd_queue_controller #(
        .DEPTH(DEPTH), .ADDR_WIDTH(3), .SETUP_CYCLES(S), .HOLD_CYCLES(H), .GAP_CYCLES(G)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    // Reference model: queue of words, sticky flag, and position within a transfer (0 = idle).
    logic [31:0] q[$];
    logic        m_ov = 1'b0;
    logic [31:0] m_cmd = '0;
    int          m_pos = 0;
    int          rises[$];
    logic [31:0] rise_cmd[$];
    logic        prev_latch = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        logic issue;
        @(posedge clock);
        cyc++;
        if (!reset_n) begin
            q.delete();
            m_ov  = 1'b0;
            m_pos = 0;
            m_cmd = '0;
        end else begin
            issue = m_pos == 0 && q.size() > 0 && !bus.hold && (!bus.sync_to_cycle || bus.update_cycle_complete);
            if (bus.cmd_in_valid && q.size() == DEPTH && !issue) m_ov = 1'b1;
            else if (bus.clear_overflow) m_ov = 1'b0;
            if (issue) m_cmd = q.pop_front();
            if (bus.cmd_in_valid && q.size() < DEPTH) q.push_back(bus.cmd_in);
            if (issue) m_pos = 1;
            else if (m_pos > 0) m_pos = m_pos == TOTAL ? 0 : m_pos + 1;
        end
        #1;
        chk("latch", bus.latch_data, 32'(m_pos > S && m_pos <= S + H));
        chk("busy", bus.busy, 32'(m_pos != 0));
        chk("level", bus.fifo_level, q.size());
        chk("empty", bus.fifo_empty, 32'(q.size() == 0));
        chk("full", bus.fifo_full, 32'(q.size() == DEPTH));
        chk("overflow", bus.overflow, 32'(m_ov));
        chk("cmd_data", bus.cmd_data, m_cmd);
        if (bus.latch_data && !prev_latch) begin
            rises.push_back(cyc);
            rise_cmd.push_back(bus.cmd_data);
        end
        prev_latch = bus.latch_data;
    endtask

    initial begin
        logic [31:0] words[$];
        int push_cyc;
        int n;
        reset_n                   = 1'b0;
        bus.cmd_in                = '0;
        bus.cmd_in_valid          = 1'b0;
        bus.sync_to_cycle         = 1'b0;
        bus.update_cycle_complete = 1'b0;
        bus.hold                  = 1'b0;
        bus.clear_overflow        = 1'b0;
        repeat (3) step();
        chk("rst_empty", bus.fifo_empty, 1);
        chk("rst_level", bus.fifo_level, 0);
        chk("rst_latch", bus.latch_data, 0);
        reset_n = 1'b1;
        step();

        // Single word: latency, strobe width, return to idle
        bus.cmd_in       = 32'hA5A5_0001;
        bus.cmd_in_valid = 1'b1;
        push_cyc         = cyc;
        step();
        bus.cmd_in_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.latch_data; i++) step();
        chk("t1_latency", cyc - push_cyc, 2 + S);
        chk("t1_cmd", bus.cmd_data, 32'hA5A5_0001);
        n = 0;
        while (bus.latch_data && n < 20) begin
            step();
            n++;
        end
        chk("t1_hold_len", n, H);
        repeat (G) step();
        chk("t1_busy", bus.busy, 0);
        chk("t1_empty", bus.fifo_empty, 1);

        // Ten pushes under hold: two dropped, eight issued in order 11 cycles apart
        bus.hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.cmd_in       = {8'(i + 1), 24'($urandom)};
            bus.cmd_in_valid = 1'b1;
            words.push_back(bus.cmd_in);
            step();
        end
        bus.cmd_in_valid = 1'b0;
        step();
        chk("t2_full", bus.fifo_full, 1);
        chk("t2_level", bus.fifo_level, 8);
        chk("t2_overflow", bus.overflow, 1);
        rises.delete();
        rise_cmd.delete();
        bus.hold = 1'b0;
        repeat (8 * 11 + 4) step();
        chk("t2_rises", rises.size(), 8);
        for (int i = 1; i < rises.size(); i++) chk("t2_period", rises[i] - rises[i-1], 1 + S + H + G);
        for (int i = 0; i < rise_cmd.size() && i < 8; i++) chk("t2_order", rise_cmd[i], words[i]);

        // Overflow clear, and a drop winning over a clear
        bus.clear_overflow = 1'b1;
        step();
        bus.clear_overflow = 1'b0;
        chk("t6_clear", bus.overflow, 0);
        bus.hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.cmd_in       = $urandom;
            bus.cmd_in_valid = 1'b1;
            step();
        end
        bus.cmd_in_valid = 1'b0;
        chk("t6_set", bus.overflow, 1);
        bus.clear_overflow = 1'b1;
        step();
        chk("t6_clear_alone", bus.overflow, 0);
        bus.cmd_in       = $urandom;
        bus.cmd_in_valid = 1'b1;
        step();
        chk("t6_drop_wins", bus.overflow, 1);
        bus.cmd_in_valid = 1'b0;
        step();
        bus.clear_overflow = 1'b0;
        chk("t6_clear_again", bus.overflow, 0);

        // Push on the same cycle the full FIFO pops, then keep it topped up across wrap-around
        bus.hold         = 1'b0;
        bus.cmd_in       = $urandom;
        bus.cmd_in_valid = 1'b1;
        step();
        chk("t3_level", bus.fifo_level, 8);
        chk("t3_overflow", bus.overflow, 0);
        rises.delete();
        repeat (250) begin
            bus.cmd_in       = $urandom;
            bus.cmd_in_valid = q.size() < DEPTH && $urandom_range(0, 1) == 1;
            step();
        end
        bus.cmd_in_valid = 1'b0;
        chk("t3_issued_20", 32'(rises.size() >= 20), 1);
        repeat (100) step();
        chk("t3_drained", bus.fifo_empty, 1);

        // Issue deferred to update cycle boundaries
        bus.sync_to_cycle = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.cmd_in       = $urandom;
            bus.cmd_in_valid = 1'b1;
            step();
        end
        bus.cmd_in_valid = 1'b0;
        rises.delete();
        repeat (50) step();
        chk("t4_wait", rises.size(), 0);
        bus.update_cycle_complete = 1'b1;
        step();
        bus.update_cycle_complete = 1'b0;
        repeat (20) step();
        chk("t4_one", rises.size(), 1);
        chk("t4_level1", bus.fifo_level, 1);
        bus.update_cycle_complete = 1'b1;
        step();
        bus.update_cycle_complete = 1'b0;
        repeat (20) step();
        chk("t4_two", rises.size(), 2);
        chk("t4_level0", bus.fifo_level, 0);
        bus.sync_to_cycle = 1'b0;

        // Reset in the middle of a strobe
        for (int i = 0; i < 2; i++) begin
            bus.cmd_in       = $urandom;
            bus.cmd_in_valid = 1'b1;
            step();
        end
        bus.cmd_in_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.latch_data; i++) step();
        chk("t5_in_strobe", bus.latch_data, 1);
        reset_n = 1'b0;
        step();
        chk("t5_latch", bus.latch_data, 0);
        chk("t5_level", bus.fifo_level, 0);
        chk("t5_cmd", bus.cmd_data, 0);
        reset_n = 1'b1;
        rises.delete();
        repeat (20) step();
        chk("t5_no_issue", rises.size(), 0);

        // Random mix of every control input
        repeat (400) begin
            bus.cmd_in                = $urandom;
            bus.cmd_in_valid          = $urandom_range(0, 9) < 3;
            bus.hold                  = $urandom_range(0, 9) < 2;
            bus.sync_to_cycle         = $urandom_range(0, 9) < 3;
            bus.update_cycle_complete = $urandom_range(0, 9) < 4;
            bus.clear_overflow        = $urandom_range(0, 19) == 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
